nf10_pkt_stats_tap: RTL and testbench
=====================================

# nf10_pkt_stats_tap

Inline AXI4-Stream stage placed directly downstream of the packet cutter in the monitor datapath, before the host DMA path. It passes every beat through a 2-entry skid buffer, so there is no combinational path between the master and slave interfaces. It also accumulates packet, byte and maximum-length statistics for the post-cut stream. The byte count per beat is derived from TSTRB, so the statistics reflect the actual truncated sizes the cutter produces.

## Interface
- C_AXIS_DATA_WIDTH, 256, TDATA width on both sides; TSTRB is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, TUSER width; TUSER is passed through untouched.
- COUNT_WIDTH, 64, width of pkt_count and byte_count.
- axi_aclk  in  1  single clock for all logic.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata / tstrb / tuser / tvalid / tlast  in  widths per params  upstream stream, fed by the cutter.
- s_axis_tready  out  1  registered ready.
- m_axis_tdata / tstrb / tuser / tvalid / tlast  out  widths per params  downstream stream.
- m_axis_tready  in  1  downstream ready.
- stats_clear  in  1  single-cycle pulse that zeroes all statistics.
- stats_freeze  in  1  level; statistics hold while it is high, and data still flows.
- pkt_count  out  COUNT_WIDTH  number of completed packets (TLAST beats accepted).
- byte_count  out  COUNT_WIDTH  bytes in completed packets.
- max_pkt_len  out  16  largest completed packet length in bytes.
- err_count  out  32  malformed-beat count; present only with the macro.

## Operation
- **Skid buffer:** 2 entries, slots A (output) and B (overflow). Occupancy is tracked as EMPTY, ONE or FULL.
  - s_axis_tready is 1 when occupancy is EMPTY or ONE. It is registered.
  - m_axis_* is driven from slot A only.
- **Occupancy transitions** (in = input handshake, out = output handshake):
  - EMPTY: in -> ONE.
  - ONE: in and no out -> FULL; out and no in -> EMPTY; both -> ONE, with the new beat in A.
  - FULL: out -> ONE, with B moving to A. s_axis_tready is 0 while FULL.
- **Beat bytes:** popcount of s_axis_tstrb, counted on every input handshake. Width is log2(C_AXIS_DATA_WIDTH/8)+1.
- **Packet length accumulator:** cur_len, 16 bits.
  - Adds the beat bytes on each non-last input handshake.
  - Saturates at 0xFFFF.
  - Resets to 0 after a TLAST beat.
- **On a TLAST input handshake,** with len = sat(cur_len + beat bytes):
  - pkt_count += 1
  - byte_count += len
  - max_pkt_len = max(max_pkt_len, len)
- **Wrap and saturation:** pkt_count and byte_count wrap modulo 2^COUNT_WIDTH. max_pkt_len saturates by construction.
- **stats_freeze high:** pkt_count, byte_count, max_pkt_len and err_count hold. cur_len keeps tracking so packet boundaries stay correct.
- **stats_clear:**
  - On the next edge, pkt_count, byte_count, max_pkt_len and err_count become 0.
  - cur_len is not cleared; a packet in flight is counted in full when its TLAST arrives after the clear.
  - Clear beats a simultaneous update: a TLAST arriving in the clear cycle is dropped from the statistics.
  - Clear also beats freeze.

## Timing
- **Reset values** (applied immediately on axi_resetn low):
  - m_axis_tvalid=0, m_axis_tdata/tstrb/tuser/tlast=0.
  - s_axis_tready=0.
  - All counters=0, cur_len=0, occupancy=EMPTY.
- **Exit from reset:** s_axis_tready rises on the first axi_aclk rising edge after axi_resetn deasserts.
- **Latency:** an accepted beat appears on m_axis in the following cycle. Throughput is 1 beat per cycle with m_axis_tready held high.
- **Output stability:** m_axis_* is stable while m_axis_tvalid=1 and m_axis_tready=0. No beat is lost or duplicated across a FULL stall.
- **Statistics timing:** outputs update in the cycle after the TLAST input handshake.
- **Reset mid-packet:** buffered beats are discarded and cur_len returns to 0. The next beat is treated as a start of packet.

## Configuration
- Macro: PKT_STATS_TSTRB_CHECK_EN.
- **Defined:** err_count is present. A beat is malformed when any of the following holds:
  - TSTRB is 0;
  - TSTRB is not contiguous from bit 0 (i.e. not of the form 2^k-1);
  - TSTRB is not all-ones on a non-TLAST beat.
- **Malformed-beat counting:** err_count increments by 1 per malformed beat and saturates at 0xFFFFFFFF. It obeys freeze and clear like the other counters. Malformed beats are still forwarded and counted in the byte statistics.
- **Undefined:** no check logic is built and err_count is tied to 0.

## Test plan
- **Single packet:** reset, then a 3-beat packet with tstrb all-ones, all-ones, 0x0000_FFFF and m_axis_tready=1.
  - Output matches the input one cycle later.
  - pkt_count=1, byte_count=80, max_pkt_len=80.
- **Backpressure:** m_axis_tready=0 for 5 cycles while a packet streams.
  - s_axis_tready drops after 2 beats are accepted.
  - Output beats are in order with no loss or duplicate.
  - Counters match the no-stall run.
- **Clear versus TLAST:** stats_clear pulsed in the same cycle as a 64-byte packet's TLAST -> all counters 0. The next 64-byte packet gives pkt_count=1, byte_count=64.
- **Freeze:** stats_freeze=1 across two 128-byte packets -> counters unchanged. After release, one 32-byte packet gives +1 packet, +32 bytes.
- **Reset mid-packet:** assert axi_resetn=0 in the middle of the 2nd beat.
  - m_axis_tvalid=0 and counters=0 immediately.
  - A following 1-beat 10-byte packet (tstrb=0x3FF) counts as len=10.
- **Tstrb check (macro defined):** non-last beat with tstrb=0x7F, then a last beat with tstrb=0x5 -> err_count=2, byte_count=9, both beats forwarded unchanged.

Source files
------------

// File: rtl/nf10_pkt_stats_tap.sv
// nf10_pkt_stats_tap: inline AXI4-Stream tap with a 2-entry skid buffer and
// post-cut packet statistics (packet count, byte count, max packet length).
// Optional feature: define PKT_STATS_TSTRB_CHECK_EN to build the malformed
// TSTRB checker behind err_count; otherwise err_count is tied to zero.
module nf10_pkt_stats_tap #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int COUNT_WIDTH        = 64
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            stats_clear,
  input  logic                            stats_freeze,
  output logic [COUNT_WIDTH-1:0]          pkt_count,
  output logic [COUNT_WIDTH-1:0]          byte_count,
  output logic [15:0]                     max_pkt_len,
  output logic [31:0]                     err_count
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int BB_W   = $clog2(STRB_W) + 1;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Number of enabled byte lanes in a beat.
  function automatic logic [BB_W-1:0] popcount(input logic [STRB_W-1:0] v);
    logic [BB_W-1:0] c;
    c = '0;
    for (int i = 0; i < STRB_W; i++) begin
      c = c + {{(BB_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // 16-bit length accumulate that sticks at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [BB_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Skid buffer state: slot A drives the master side, slot B absorbs one overflow beat.
  logic [1:0]                    occ_q, occ_d;
  logic                          s_ready_q;
  logic                          a_valid_q;
  logic [C_AXIS_DATA_WIDTH-1:0]  a_data_q, b_data_q;
  logic [STRB_W-1:0]             a_strb_q, b_strb_q;
  logic [C_AXIS_TUSER_WIDTH-1:0] a_user_q, b_user_q;
  logic                          a_last_q, b_last_q;

  logic in_hs_s, out_hs_s;
  logic a_ld_in_s, a_ld_b_s, b_ld_s;

  assign in_hs_s  = s_axis_tvalid & s_ready_q;
  assign out_hs_s = a_valid_q & m_axis_tready;

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = a_valid_q;
  assign m_axis_tdata  = a_data_q;
  assign m_axis_tstrb  = a_strb_q;
  assign m_axis_tuser  = a_user_q;
  assign m_axis_tlast  = a_last_q;

  // Occupancy next-state and slot load selection.
  always_comb begin
    occ_d     = occ_q;
    a_ld_in_s = 1'b0;
    a_ld_b_s  = 1'b0;
    b_ld_s    = 1'b0;
    case (occ_q)
      OCC_EMPTY: begin
        if (in_hs_s) begin
          occ_d     = OCC_ONE;
          a_ld_in_s = 1'b1;
        end else begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (in_hs_s && !out_hs_s) begin
          occ_d  = OCC_FULL;
          b_ld_s = 1'b1;
        end else if (out_hs_s && !in_hs_s) begin
          occ_d = OCC_EMPTY;
        end else if (in_hs_s && out_hs_s) begin
          occ_d     = OCC_ONE;
          a_ld_in_s = 1'b1;
        end else begin
          occ_d = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (out_hs_s) begin
          occ_d    = OCC_ONE;
          a_ld_b_s = 1'b1;
        end else begin
          occ_d = OCC_FULL;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Skid buffer registers; ready and valid are registered from the next occupancy.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      occ_q     <= OCC_EMPTY;
      s_ready_q <= 1'b0;
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_strb_q  <= '0;
      a_user_q  <= '0;
      a_last_q  <= 1'b0;
      b_data_q  <= '0;
      b_strb_q  <= '0;
      b_user_q  <= '0;
      b_last_q  <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      s_ready_q <= (occ_d != OCC_FULL);
      a_valid_q <= (occ_d != OCC_EMPTY);
      if (a_ld_in_s) begin
        a_data_q <= s_axis_tdata;
        a_strb_q <= s_axis_tstrb;
        a_user_q <= s_axis_tuser;
        a_last_q <= s_axis_tlast;
      end else if (a_ld_b_s) begin
        a_data_q <= b_data_q;
        a_strb_q <= b_strb_q;
        a_user_q <= b_user_q;
        a_last_q <= b_last_q;
      end
      if (b_ld_s) begin
        b_data_q <= s_axis_tdata;
        b_strb_q <= s_axis_tstrb;
        b_user_q <= s_axis_tuser;
        b_last_q <= s_axis_tlast;
      end
    end
  end

  // Statistics state.
  logic [15:0]            cur_len_q, cur_len_d;
  logic [COUNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [COUNT_WIDTH-1:0] bytes_q, bytes_d;
  logic [15:0]            max_q, max_d;
  logic [BB_W-1:0]        beat_bytes_s;
  logic [15:0]            len_s;

  assign beat_bytes_s = popcount(s_axis_tstrb);
  assign len_s        = sat_add16(cur_len_q, beat_bytes_s);

  assign pkt_count   = pkt_q;
  assign byte_count  = bytes_q;
  assign max_pkt_len = max_q;

  // Packet length tracking (ignores freeze/clear so boundaries stay aligned) and counter updates.
  always_comb begin
    cur_len_d = cur_len_q;
    pkt_d     = pkt_q;
    bytes_d   = bytes_q;
    max_d     = max_q;
    if (in_hs_s) begin
      cur_len_d = s_axis_tlast ? 16'd0 : len_s;
    end else begin
      cur_len_d = cur_len_q;
    end
    if (stats_clear) begin
      pkt_d   = '0;
      bytes_d = '0;
      max_d   = 16'd0;
    end else if (stats_freeze) begin
      pkt_d   = pkt_q;
      bytes_d = bytes_q;
      max_d   = max_q;
    end else if (in_hs_s && s_axis_tlast) begin
      pkt_d   = pkt_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      bytes_d = bytes_q + COUNT_WIDTH'(len_s);
      max_d   = (len_s > max_q) ? len_s : max_q;
    end else begin
      pkt_d   = pkt_q;
      bytes_d = bytes_q;
      max_d   = max_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cur_len_q <= 16'd0;
      pkt_q     <= '0;
      bytes_q   <= '0;
      max_q     <= 16'd0;
    end else begin
      cur_len_q <= cur_len_d;
      pkt_q     <= pkt_d;
      bytes_q   <= bytes_d;
      max_q     <= max_d;
    end
  end

`ifdef PKT_STATS_TSTRB_CHECK_EN
  // A beat is malformed if TSTRB is empty, not a low-aligned mask, or partial on a non-last beat.
  function automatic logic strb_malformed(input logic [STRB_W-1:0] s, input logic last);
    logic contig;
    contig = ((s & (s + {{(STRB_W-1){1'b0}}, 1'b1})) == {STRB_W{1'b0}});
    return (s == {STRB_W{1'b0}}) | ~contig | (~last & (s != {STRB_W{1'b1}}));
  endfunction

  logic [31:0] err_q, err_d;

  assign err_count = err_q;

  // Saturating malformed-beat counter with the same clear/freeze priority as the other counters.
  always_comb begin
    err_d = err_q;
    if (stats_clear) begin
      err_d = 32'd0;
    end else if (stats_freeze) begin
      err_d = err_q;
    end else if (in_hs_s && strb_malformed(s_axis_tstrb, s_axis_tlast) && (err_q != 32'hFFFF_FFFF)) begin
      err_d = err_q + 32'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Malformed-beat counter register.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      err_q <= 32'd0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign err_count = 32'd0;
`endif

endmodule

// File: tb/tb_nf10_pkt_stats_tap.sv
// Self-checking bench for nf10_pkt_stats_tap: directed scenarios plus randomized
// traffic checked against a packet-level reference model and an output scoreboard.
module tb_nf10_pkt_stats_tap;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic         stats_clear = 1'b0;
  logic         stats_freeze = 1'b0;
  logic [63:0]  pkt_count;
  logic [63:0]  byte_count;
  logic [15:0]  max_pkt_len;
  logic [31:0]  err_count;

  int checks = 0;
  int failures = 0;

  nf10_pkt_stats_tap dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .stats_clear(stats_clear), .stats_freeze(stats_freeze),
    .pkt_count(pkt_count), .byte_count(byte_count), .max_pkt_len(max_pkt_len), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  int           m_cur = 0;
  logic [63:0]  m_pkt = '0;
  logic [63:0]  m_bytes = '0;
  int           m_max = 0;
  logic [31:0]  m_err = '0;
  bit           hold_pending = 0;
  beat_t        held;

  function automatic bit tb_malformed(input logic [31:0] s, input logic l);
    bit is_mask = 0;
    for (int k = 0; k <= 32; k++) begin
      if ({32'h0, s} == ((64'd1 << k) - 64'd1)) is_mask = 1;
    end
    return (s == 32'h0) || !is_mask || (!l && s != 32'hFFFF_FFFF);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] mask_n(input int n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cur = 0; m_pkt = '0; m_bytes = '0; m_max = 0; m_err = '0;
    hold_pending = 0;
  endtask

  // Per-cycle monitor: stats compare, output stability, scoreboard, then model update for the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (pkt_count !== m_pkt || byte_count !== m_bytes || max_pkt_len !== 16'(m_max) || err_count !== m_err) begin
        failures++;
        $display("FAIL stats_track t=%0t got pkt=%0d bytes=%0d max=%0d err=%0d want pkt=%0d bytes=%0d max=%0d err=%0d",
                 $time, pkt_count, byte_count, max_pkt_len, err_count, m_pkt, m_bytes, m_max, m_err);
      end
      if (hold_pending) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held.d || m_axis_tstrb !== held.s ||
            m_axis_tuser !== held.u || m_axis_tlast !== held.l) begin
          failures++;
          $display("FAIL out_stable t=%0t got valid=%0b strb=%h want valid=1 strb=%h", $time, m_axis_tvalid, m_axis_tstrb, held.s);
        end
      end
      hold_pending = m_axis_tvalid && !m_axis_tready;
      held = '{d: m_axis_tdata, s: m_axis_tstrb, u: m_axis_tuser, l: m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_beat t=%0t got unexpected beat strb=%h want none", $time, m_axis_tstrb);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tstrb !== e.s || m_axis_tuser !== e.u || m_axis_tlast !== e.l) begin
            failures++;
            $display("FAIL out_beat t=%0t got strb=%h last=%0b data=%h want strb=%h last=%0b data=%h",
                     $time, m_axis_tstrb, m_axis_tlast, m_axis_tdata[63:0], e.s, e.l, e.d[63:0]);
          end
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        int len;
        exp_q.push_back('{d: s_axis_tdata, s: s_axis_tstrb, u: s_axis_tuser, l: s_axis_tlast});
        len = m_cur + $countones(s_axis_tstrb);
        if (len > 65535) len = 65535;
        if (s_axis_tlast) begin
          m_cur = 0;
          if (!stats_clear && !stats_freeze) begin
            m_pkt = m_pkt + 64'd1;
            m_bytes = m_bytes + 64'(len);
            if (len > m_max) m_max = len;
          end
        end else begin
          m_cur = len;
        end
`ifdef PKT_STATS_TSTRB_CHECK_EN
        if (!stats_clear && !stats_freeze && tb_malformed(s_axis_tstrb, s_axis_tlast) && m_err != 32'hFFFF_FFFF)
          m_err = m_err + 32'd1;
`endif
      end
      if (stats_clear) begin
        m_pkt = '0; m_bytes = '0; m_max = 0; m_err = '0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the beat's handshake edge.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                           input logic l, input logic clr);
    bit done = 0;
    int budget = 0;
    s_axis_tdata = d; s_axis_tstrb = s; s_axis_tuser = u; s_axis_tlast = l;
    s_axis_tvalid = 1'b1; stats_clear = clr;
    while (!done) begin
      @(negedge clk);
      done = s_axis_tready;
      @(posedge clk); #1;
      budget++;
      if (!done && budget > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout got no handshake in %0d cycles want handshake", budget);
        done = 1;
      end
    end
    s_axis_tvalid = 1'b0; stats_clear = 1'b0;
  endtask

  task automatic send_pkt(input int nfull, input logic [31:0] last_strb);
    for (int i = 0; i < nfull; i++) send_beat(rand256(), 32'hFFFF_FFFF, rand128(), 1'b0, 1'b0);
    send_beat(rand256(), last_strb, rand128(), 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    s_axis_tvalid = 1'b0; stats_clear = 1'b0; stats_freeze = 1'b0; m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    m_axis_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d beats still owed want 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 256'h0 || m_axis_tlast !== 1'b0) begin
      failures++; $display("FAIL reset_out got valid=%0b last=%0b want 0 0", m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got %0b want 0", s_axis_tready);
    end
    checks++;
    if (pkt_count !== 64'h0 || byte_count !== 64'h0 || max_pkt_len !== 16'h0 || err_count !== 32'h0) begin
      failures++; $display("FAIL reset_stats got pkt=%0d bytes=%0d max=%0d err=%0d want 0", pkt_count, byte_count, max_pkt_len, err_count);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++; $display("FAIL ready_before_edge got %0b want 0", s_axis_tready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++; $display("FAIL ready_after_edge got %0b want 1", s_axis_tready);
    end
  endtask

  task automatic test_single_packet();
    logic [31:0] strbs [3];
    strbs[0] = 32'hFFFF_FFFF; strbs[1] = 32'hFFFF_FFFF; strbs[2] = 32'h0000_FFFF;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [255:0] d;
      logic [127:0] u;
      d = rand256(); u = rand128();
      send_beat(d, strbs[i], u, (i == 2), 1'b0);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_tstrb !== strbs[i] || m_axis_tuser !== u || m_axis_tlast !== (i == 2)) begin
        failures++; $display("FAIL latency beat%0d got valid=%0b strb=%h want valid=1 strb=%h", i, m_axis_tvalid, m_axis_tstrb, strbs[i]);
      end
    end
    drain();
    checks++;
    if (pkt_count !== 64'd1 || byte_count !== 64'd80 || max_pkt_len !== 16'd80) begin
      failures++; $display("FAIL single_pkt got pkt=%0d bytes=%0d max=%0d want 1 80 80", pkt_count, byte_count, max_pkt_len);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d0;
    do_reset();
    d0 = rand256();
    m_axis_tready = 1'b0;
    fork
      begin
        send_beat(d0, 32'hFFFF_FFFF, rand128(), 1'b0, 1'b0);
        send_pkt(2, 32'h0000_FFFF);
      end
      begin
        repeat (2) @(posedge clk); #1;
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tdata !== d0) begin
          failures++; $display("FAIL bp_full got ready=%0b data=%h want ready=0 data=%h", s_axis_tready, m_axis_tdata[63:0], d0[63:0]);
        end
        repeat (3) @(posedge clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    drain();
    checks++;
    if (pkt_count !== 64'd1 || byte_count !== 64'd112 || max_pkt_len !== 16'd112) begin
      failures++; $display("FAIL bp_stats got pkt=%0d bytes=%0d max=%0d want 1 112 112", pkt_count, byte_count, max_pkt_len);
    end
  endtask

  task automatic test_clear_vs_tlast();
    do_reset();
    send_beat(rand256(), 32'hFFFF_FFFF, rand128(), 1'b0, 1'b0);
    send_pkt(1, 32'h0000_0000);
    send_beat(rand256(), 32'hFFFF_FFFF, rand128(), 1'b0, 1'b0);
    send_beat(rand256(), 32'hFFFF_FFFF, rand128(), 1'b1, 1'b1);
    drain();
    checks++;
    if (pkt_count !== 64'd0 || byte_count !== 64'd0 || max_pkt_len !== 16'd0 || err_count !== 32'd0) begin
      failures++; $display("FAIL clear_tlast got pkt=%0d bytes=%0d max=%0d err=%0d want 0", pkt_count, byte_count, max_pkt_len, err_count);
    end
    send_pkt(1, 32'hFFFF_FFFF);
    drain();
    checks++;
    if (pkt_count !== 64'd1 || byte_count !== 64'd64 || max_pkt_len !== 16'd64) begin
      failures++; $display("FAIL clear_next got pkt=%0d bytes=%0d max=%0d want 1 64 64", pkt_count, byte_count, max_pkt_len);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    stats_freeze = 1'b1;
    send_pkt(3, 32'hFFFF_FFFF);
    send_pkt(3, 32'hFFFF_FFFF);
    drain();
    checks++;
    if (pkt_count !== 64'd0 || byte_count !== 64'd0 || max_pkt_len !== 16'd0) begin
      failures++; $display("FAIL freeze_hold got pkt=%0d bytes=%0d max=%0d want 0 0 0", pkt_count, byte_count, max_pkt_len);
    end
    stats_freeze = 1'b0;
    send_pkt(0, 32'hFFFF_FFFF);
    drain();
    checks++;
    if (pkt_count !== 64'd1 || byte_count !== 64'd32 || max_pkt_len !== 16'd32) begin
      failures++; $display("FAIL freeze_release got pkt=%0d bytes=%0d max=%0d want 1 32 32", pkt_count, byte_count, max_pkt_len);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_pkt(1, 32'h0000_FFFF);
    send_beat(rand256(), 32'hFFFF_FFFF, rand128(), 1'b0, 1'b0);
    s_axis_tdata = rand256(); s_axis_tstrb = 32'hFFFF_FFFF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      failures++; $display("FAIL midreset_out got valid=%0b ready=%0b want 0 0", m_axis_tvalid, s_axis_tready);
    end
    checks++;
    if (pkt_count !== 64'd0 || byte_count !== 64'd0 || max_pkt_len !== 16'd0) begin
      failures++; $display("FAIL midreset_stats got pkt=%0d bytes=%0d max=%0d want 0", pkt_count, byte_count, max_pkt_len);
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(0, 32'h0000_03FF);
    drain();
    checks++;
    if (pkt_count !== 64'd1 || byte_count !== 64'd10 || max_pkt_len !== 16'd10) begin
      failures++; $display("FAIL midreset_next got pkt=%0d bytes=%0d max=%0d want 1 10 10", pkt_count, byte_count, max_pkt_len);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send_pkt(2100, 32'h0000_0001);
    send_pkt(0, 32'h0000_000F);
    drain();
    checks++;
    if (pkt_count !== 64'd2 || byte_count !== 64'd65539 || max_pkt_len !== 16'hFFFF) begin
      failures++; $display("FAIL saturation got pkt=%0d bytes=%0d max=%0d want 2 65539 65535", pkt_count, byte_count, max_pkt_len);
    end
  endtask

`ifdef PKT_STATS_TSTRB_CHECK_EN
  task automatic test_tstrb_check();
    do_reset();
    send_beat(rand256(), 32'h0000_007F, rand128(), 1'b0, 1'b0);
    send_beat(rand256(), 32'h0000_0005, rand128(), 1'b1, 1'b0);
    drain();
    checks++;
    if (err_count !== 32'd2 || byte_count !== 64'd9 || pkt_count !== 64'd1) begin
      failures++; $display("FAIL tstrb_check got err=%0d bytes=%0d pkt=%0d want 2 9 1", err_count, byte_count, pkt_count);
    end
  endtask
`endif

  task automatic test_random();
    bit rand_done = 0;
    do_reset();
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          int nb;
          nb = $urandom_range(1, 5);
          for (int b = 0; b < nb; b++) begin
            logic        l;
            logic [31:0] s;
            l = (b == nb - 1);
            if ($urandom_range(0, 7) == 0) s = $urandom;
            else if (l) s = mask_n($urandom_range(1, 32));
            else s = 32'hFFFF_FFFF;
            send_beat(rand256(), s, rand128(), l, ($urandom_range(0, 15) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          m_axis_tready = ($urandom_range(0, 3) != 0);
        end
        m_axis_tready = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          stats_freeze = ($urandom_range(0, 7) == 0);
        end
        stats_freeze = 1'b0;
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_clear_vs_tlast();
    test_freeze();
    test_reset_mid_packet();
    test_saturation();
`ifdef PKT_STATS_TSTRB_CHECK_EN
    test_tstrb_check();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got timeout at %0t want completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
